booth_mult_arbiter: RTL and testbench
=====================================

BOOTH_MULT_ARBITER -- requirements
Module: booth_mult_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, operand width in bits.
REQ-002 SHALL have parameter LAT, default 32, multiplier latency in clk cycles from mul_start to valid mul_p (LAT >= 1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  4  per-requester request valid.
REQ-006 SHALL have port req_ready  output  4  per-requester accept; one-hot or zero.
REQ-007 SHALL have port req_m  input  4*N  signed multiplier operands; requester i in bits [i*N +: N].
REQ-008 SHALL have port req_q  input  4*N  signed multiplicand operands; requester i in bits [i*N +: N].
REQ-009 SHALL have port resp_valid  output  1  result available.
REQ-010 SHALL have port resp_ready  input  1  result consumer accept.
REQ-011 SHALL have port resp_id  output  2  index of requester owning resp_p.
REQ-012 SHALL have port resp_p  output  2*N  signed product.
REQ-013 SHALL have port mul_m, mul_q  output  N each  operands driven to the shared Booth multiplier.
REQ-014 SHALL have port mul_start  output  1  one-cycle pulse loading/restarting the multiplier.
REQ-015 SHALL have port mul_p  input  2*N  multiplier product.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement states IDLE, START, RUN, DONE.
REQ-018 IDLE: grant = first requester with req_valid set, searched round-robin from pointer ptr; req_ready[grant]=1 combinationally, all other req_ready bits 0; req_ready all 0 outside IDLE.
REQ-019 Accept edge (IDLE, any req_valid): capture req_m/req_q of grant into mul_m/mul_q, grant into resp_id, set ptr = (grant+1) mod 4.
REQ-020 On accept, if captured m==0 or q==0: resp_p <= 0, go directly to DONE, no mul_start pulse; else go to START.
REQ-021 START: mul_start=1 for exactly this one cycle; next edge loads counter with LAT, goes to RUN.
REQ-022 RUN: counter decrements each edge; on the edge where counter==1, resp_p <= mul_p, go to DONE.
REQ-023 Latency: resp_valid rises LAT+2 cycles after accept edge (1 cycle for zero-operand fast path).
REQ-024 DONE: resp_valid=1, resp_p/resp_id stable; on edge with resp_ready=1 go to IDLE; resp_ready=0 holds DONE indefinitely.
REQ-025 mul_m/mul_q SHALL remain stable from accept through end of RUN.
REQ-026 Products are signed two's complement, 2*N bits; no truncation or saturation.
REQ-027 req_valid deasserting outside IDLE SHALL have no effect; accepted operation always completes.
REQ-028 Same-cycle resp_ready handshake and new request: new accept earliest on cycle after DONE->IDLE (no back-to-back bypass).
REQ-029 ptr wraps 3 -> 0; a requester with continuous req_valid is served at most once per 4 accepts when all four request.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, ptr=0, counter=0, req_ready=0, resp_valid=0, resp_id=0, resp_p=0, mul_m=0, mul_q=0, mul_start=0, busy=0.
REQ-031 rst mid-operation (START/RUN/DONE) SHALL discard the operation; no response is produced for it after release.
REQ-032 First accept after rst release SHALL occur no earlier than the first rising edge with rst=0.

Verification
REQ-033 Requester 1 alone, m=5, q=7 -> req_ready[1] one cycle, one mul_start pulse, resp_valid after LAT+2 cycles, resp_p=35, resp_id=1.
REQ-034 All four valid from reset, operands (1,2),(3,10),(12,5),(7,7), resp_ready=1 -> responses in order id 0,1,2,3 with 2,30,60,49; then id 0 again.
REQ-035 m=-3, q=10 on requester 2 -> resp_p=-30 (64-bit sign-extended), resp_id=2.
REQ-036 m=0, q=12345 -> resp_valid one cycle after accept, resp_p=0, mul_start never asserted.
REQ-037 resp_ready held 0 for 10 cycles in DONE with other requests pending -> resp_valid, resp_p, resp_id stable, req_ready stays 0, no mul_start.
REQ-038 rst pulsed in RUN -> all outputs zero at once; after release, requester 0 granted first, no stale response.

Source files
------------

// File: rtl/booth_mult_arbiter.sv
// Round-robin front end sharing one external Booth multiplier among four requesters.
// Operands with a zero factor skip the multiplier and complete in a single cycle.
module booth_mult_arbiter #(
    parameter int N   = 32,
    parameter int LAT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req_valid,
    output logic [3:0]       req_ready,
    input  logic [4*N-1:0]   req_m,
    input  logic [4*N-1:0]   req_q,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [1:0]       resp_id,
    output logic [2*N-1:0]   resp_p,
    output logic [N-1:0]     mul_m,
    output logic [N-1:0]     mul_q,
    output logic             mul_start,
    input  logic [2*N-1:0]   mul_p,
    output logic             busy
);

    localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t              state;
    logic [1:0]          ptr;
    logic [CNT_W-1:0]    cnt;

    logic                gnt_vld;
    logic [1:0]          gnt_idx;
    logic [1:0]          cand;
    logic signed [N-1:0] m_arr [4];
    logic signed [N-1:0] q_arr [4];
    logic signed [N-1:0] sel_m;
    logic signed [N-1:0] sel_q;

    function automatic logic has_zero_operand(input logic signed [N-1:0] a,
                                              input logic signed [N-1:0] b);
        return (a == '0) || (b == '0);
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            m_arr[i] = req_m[i*N +: N];
            q_arr[i] = req_q[i*N +: N];
        end
    end

    // Scan downward so the requester closest to ptr overwrites the others.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr;
        cand    = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign sel_m = m_arr[gnt_idx];
    assign sel_q = q_arr[gnt_idx];

    // Reset is folded in so no grant leaks out while the FSM is held in reset.
    assign req_ready = (state == IDLE && gnt_vld && !rst) ? (4'b0001 << gnt_idx) : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 2'd0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 2'd0;
            resp_p     <= '0;
            mul_m      <= '0;
            mul_q      <= '0;
            mul_start  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        mul_m   <= sel_m;
                        mul_q   <= sel_q;
                        resp_id <= gnt_idx;
                        ptr     <= gnt_idx + 2'd1;
                        busy    <= 1'b1;
                        if (has_zero_operand(sel_m, sel_q)) begin
                            resp_p     <= '0;
                            resp_valid <= 1'b1;
                            state      <= DONE;
                        end else begin
                            mul_start <= 1'b1;
                            state     <= START;
                        end
                    end
                end
                START: begin
                    cnt   <= CNT_W'(LAT);
                    state <= RUN;
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        resp_p     <= mul_p;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a behavioural fixed-latency multiplier.
module tb_booth_mult_arbiter;

    localparam int N   = 32;
    localparam int LAT = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     req_valid;
    logic [3:0]     req_ready;
    logic [4*N-1:0] req_m;
    logic [4*N-1:0] req_q;
    logic           resp_valid;
    logic           resp_ready;
    logic [1:0]     resp_id;
    logic [2*N-1:0] resp_p;
    logic [N-1:0]   mul_m;
    logic [N-1:0]   mul_q;
    logic           mul_start;
    logic [2*N-1:0] mul_p;
    logic           busy;

    int tests = 0;
    int fails = 0;
    int starts = 0;
    int mk = 0;
    logic signed [2*N-1:0] prod_hold;
    logic signed [2*N-1:0] ea;
    logic signed [2*N-1:0] eb;

    booth_mult_arbiter #(.N(N), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_m(req_m), .req_q(req_q),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_p(resp_p),
        .mul_m(mul_m), .mul_q(mul_q),
        .mul_start(mul_start), .mul_p(mul_p),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier model: garbage until LAT cycles after the start pulse.
    always @(posedge clk) begin
        if (rst) begin
            mul_p <= '0;
        end else if (mul_start) begin
            starts = starts + 1;
            ea = {{N{mul_m[N-1]}}, mul_m};
            eb = {{N{mul_q[N-1]}}, mul_q};
            prod_hold = ea * eb;
            mk = 1;
            mul_p <= (LAT == 1) ? prod_hold : 64'hA5A5_5A5A_DEAD_BEEF;
        end else if (mk != 0 && mk < LAT) begin
            mk = mk + 1;
            if (mk == LAT) mul_p <= prod_hold;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(output int n);
        n = 1;
        while (!resp_valid && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic set_op(input int i, input logic [N-1:0] m, input logic [N-1:0] q);
        req_m[i*N +: N] = m;
        req_q[i*N +: N] = q;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int s0;
        int seen;
        logic [63:0] exp_p [5];
        logic [63:0] exp_id [5];

        rst = 1'b1; req_valid = 4'hF; req_m = '0; req_q = '0; resp_ready = 1'b0;
        #1;
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_valid", 64'(resp_valid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_start", 64'(mul_start), 64'h0);
        check("rst_p", resp_p, 64'h0);
        check("rst_id", 64'(resp_id), 64'h0);
        check("rst_mulm", 64'(mul_m), 64'h0);
        tick();
        tick();
        rst = 1'b0;

        // Requester 1 alone, 5*7
        req_valid = 4'b0010;
        set_op(1, 32'd5, 32'd7);
        #1;
        check("r1_ready", 64'(req_ready), 64'h2);
        s0 = starts;
        tick();
        req_valid = 4'b0000;
        check("r1_ready_after", 64'(req_ready), 64'h0);
        check("r1_busy", 64'(busy), 64'h1);
        check("r1_start", 64'(mul_start), 64'h1);
        check("r1_mulm", 64'(mul_m), 64'd5);
        check("r1_mulq", 64'(mul_q), 64'd7);
        wait_resp(n);
        check("r1_latency", 64'(n), 64'(LAT + 2));
        check("r1_pulses", 64'(starts - s0), 64'd1);
        check("r1_p", resp_p, 64'd35);
        check("r1_id", 64'(resp_id), 64'd1);
        check("r1_mulm_hold", 64'(mul_m), 64'd5);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("r1_done_valid", 64'(resp_valid), 64'h0);
        check("r1_done_busy", 64'(busy), 64'h0);

        // Negative operand on requester 2
        req_valid = 4'b0100;
        set_op(2, -32'sd3, 32'd10);
        tick();
        req_valid = 4'b0000;
        wait_resp(n);
        check("neg_latency", 64'(n), 64'(LAT + 2));
        check("neg_p", resp_p, 64'hFFFF_FFFF_FFFF_FFE2);
        check("neg_id", 64'(resp_id), 64'd2);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Zero multiplier fast path on requester 3
        req_valid = 4'b1000;
        set_op(3, 32'd0, 32'd12345);
        s0 = starts;
        tick();
        req_valid = 4'b0000;
        wait_resp(n);
        check("zm_latency", 64'(n), 64'd1);
        check("zm_p", resp_p, 64'h0);
        check("zm_id", 64'(resp_id), 64'd3);
        tick();
        check("zm_pulses", 64'(starts - s0), 64'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Zero multiplicand fast path on requester 0
        req_valid = 4'b0001;
        set_op(0, -32'sd7, 32'd0);
        s0 = starts;
        tick();
        req_valid = 4'b0000;
        wait_resp(n);
        check("zq_latency", 64'(n), 64'd1);
        check("zq_p", resp_p, 64'h0);
        check("zq_pulses", 64'(starts - s0), 64'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Backpressure in DONE with all requesters pending
        req_valid = 4'b0010;
        set_op(1, -32'sd4, -32'sd6);
        tick();
        set_op(0, 32'd9, 32'd9);
        set_op(2, 32'd8, 32'd8);
        set_op(3, 32'd6, 32'd6);
        req_valid = 4'hF;
        wait_resp(n);
        check("bp_latency", 64'(n), 64'(LAT + 2));
        s0 = starts;
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", 64'(resp_valid), 64'h1);
            check("bp_p", resp_p, 64'd24);
            check("bp_id", 64'(resp_id), 64'd1);
            check("bp_ready", 64'(req_ready), 64'h0);
            tick();
        end
        check("bp_pulses", 64'(starts - s0), 64'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("bp_release_valid", 64'(resp_valid), 64'h0);
        check("bp_release_busy", 64'(busy), 64'h0);
        check("bp_next_grant", 64'(req_ready), 64'h4);
        req_valid = 4'b0000;
        tick();
        check("bp_no_accept", 64'(busy), 64'h0);

        // All four requesting from reset, round robin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_op(0, 32'd1, 32'd2);
        set_op(1, 32'd3, 32'd10);
        set_op(2, 32'd12, 32'd5);
        set_op(3, 32'd7, 32'd7);
        exp_p[0] = 64'd2;  exp_p[1] = 64'd30; exp_p[2] = 64'd60; exp_p[3] = 64'd49; exp_p[4] = 64'd2;
        exp_id[0] = 64'd0; exp_id[1] = 64'd1; exp_id[2] = 64'd2; exp_id[3] = 64'd3; exp_id[4] = 64'd0;
        req_valid = 4'hF;
        resp_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("rr_grant", 64'(req_ready), 64'(4'b0001 << (i % 4)));
            tick();
            wait_resp(n);
            check("rr_latency", 64'(n), 64'(LAT + 2));
            check("rr_id", 64'(resp_id), exp_id[i]);
            check("rr_p", resp_p, exp_p[i]);
            tick();
        end
        req_valid = 4'b0000;
        resp_ready = 1'b0;

        // Reset in the middle of RUN
        req_valid = 4'b1000;
        set_op(3, 32'd4, 32'd4);
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        tick();
        check("mid_busy", 64'(busy), 64'h1);
        req_valid = 4'hF;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'h0);
        check("mid_rst_valid", 64'(resp_valid), 64'h0);
        check("mid_rst_start", 64'(mul_start), 64'h0);
        check("mid_rst_p", resp_p, 64'h0);
        check("mid_rst_id", 64'(resp_id), 64'h0);
        check("mid_rst_mulm", 64'(mul_m), 64'h0);
        check("mid_rst_mulq", 64'(mul_q), 64'h0);
        check("mid_rst_ready", 64'(req_ready), 64'h0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_first_grant", 64'(req_ready), 64'h1);
        req_valid = 4'b0000;
        s0 = starts;
        seen = 0;
        for (int c = 0; c < LAT + 6; c++) begin
            tick();
            if (resp_valid) seen++;
        end
        check("mid_no_stale", 64'(seen), 64'd0);
        check("mid_idle_busy", 64'(busy), 64'h0);
        check("mid_no_start", 64'(starts - s0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
